// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - DAC playback sample FIFO with prefill and underflow repeat
//
// Purpose:
//   Decouples the filter output (anc_top) from the I2S transmitter. Samples
//   are buffered in a circular FIFO. Playback begins only once PREFILL
//   entries are stored. Before that, requests are answered with silence.
//   While running, an empty FIFO repeats the last delivered sample.
//
// Optional feature:
//   DAC_FIFO_STATS_EN - when defined, ovf_cnt/unf_cnt count overflow and
//   underflow events and saturate at 255. When undefined, both are tied to 0.
//
// Ports:
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_sample   in   WIDTH  sample from the filter (two's complement)
//   in_valid    in   1      write strobe; the producer never stalls
//   flush       in   1      synchronous clear, overrides all other inputs
//   out_req     in   1      request pulse from the I2S transmitter
//   out_sample  out  WIDTH  sample presented to the transmitter
//   out_valid   out  1      one-cycle pulse marking a new out_sample
//   level       out  AW+1   current occupancy
//   running     out  1      high in RUN state
//   ovf_cnt     out  8      overflow event count (stats build only)
//   unf_cnt     out  8      underflow event count (stats build only)

module dac_sample_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int PREFILL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_sample,
  input  logic                     in_valid,
  input  logic                     flush,
  input  logic                     out_req,
  output logic [WIDTH-1:0]         out_sample,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     running,
  output logic [7:0]               ovf_cnt,
  output logic [7:0]               unf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_out_sample;
  logic             r_out_valid;

  logic             w_empty;
  logic             w_full;
  logic             w_req_acc;
  logic             w_rd;
  logic             w_wr;
  logic [WIDTH-1:0] w_out_data;

  // Occupancy is judged on the state before this cycle's update, so a
  // write into an empty FIFO does not satisfy a read in the same cycle.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

  // A request is serviced with out_valid on the next cycle. While that
  // response is being issued, a still-asserted out_req is the same request
  // held over and is not counted again.
  assign w_req_acc = out_req & ~r_out_valid;

  always_comb begin
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_level_nxt = r_level;
    w_state_nxt = r_state;
    if (flush) begin
      w_level_nxt = '0;
      w_state_nxt = S_FILL;
    end else begin
      w_rd = w_req_acc && (r_state == S_RUN) && !w_empty;
      // When the FIFO is full, a read in the same cycle frees the slot
      // the write lands in, so the write is still accepted.
      w_wr = in_valid && (!w_full || w_rd);
      w_level_nxt = r_level + LW'(w_wr) - LW'(w_rd);
      if ((r_state == S_FILL) && (w_level_nxt >= LW'(PREFILL))) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  // In FILL the transmitter gets silence. In RUN it gets the head entry,
  // or the previous sample again when nothing is queued.
  always_comb begin
    w_out_data = '0;
    if (r_state == S_RUN) begin
      if (w_empty) begin
        w_out_data = r_last;
      end else begin
        w_out_data = r_mem[r_rptr];
      end
    end
  end

  // Sample storage is not reset. The pointers and level alone decide
  // which entries are live, so stale data is never read out.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= in_sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_last       <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_FILL;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_last      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_out_valid <= w_req_acc;
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      if (w_req_acc) begin
        r_out_sample <= w_out_data;
      end
    end
  end

  assign out_sample = r_out_sample;
  assign out_valid  = r_out_valid;
  assign level      = r_level;
  assign running    = (r_state == S_RUN);

`ifdef DAC_FIFO_STATS_EN
  logic       w_ovf;
  logic       w_unf;
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_unf_cnt;

  assign w_ovf = ~flush & in_valid & w_full & ~w_rd;
  assign w_unf = ~flush & w_req_acc & (r_state == S_RUN) & w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (flush) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      if (w_unf && (r_unf_cnt != 8'hFF)) begin
        r_unf_cnt <= r_unf_cnt + 8'd1;
      end
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign unf_cnt = r_unf_cnt;
`else
  assign ovf_cnt = 8'd0;
  assign unf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dac_sample_fifo.sv
// tb/tb_dac_sample_fifo.sv - directed self-checking bench for dac_sample_fifo

module tb_dac_sample_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
`ifdef DAC_FIFO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_sample;
  logic             in_valid;
  logic             flush;
  logic             out_req;
  logic [WIDTH-1:0] out_sample;
  logic             out_valid;
  logic [3:0]       level;
  logic             running;
  logic [7:0]       ovf_cnt;
  logic [7:0]       unf_cnt;

  int checks = 0;
  int errors = 0;

  dac_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PREFILL(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_req    (out_req),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .level      (level),
    .running    (running),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then release the one-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_req  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_sample = '0; in_valid = 0; flush = 0; out_req = 0;
    repeat (2) tick();
    checks++; if (out_sample !== 16'h0) begin errors++; $display("FAIL rst_out_sample got %h exp 0000", out_sample); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b exp 0", running); end
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL rst_ovf got %0d exp 0", ovf_cnt); end
    checks++; if (unf_cnt !== 8'd0) begin errors++; $display("FAIL rst_unf got %0d exp 0", unf_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_output();
    out_req = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", out_valid); end
    checks++; if (out_sample !== 16'h0000) begin errors++; $display("FAIL fill_sample got %h exp 0000", out_sample); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_level got %0d exp 0", level); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_prefill();
    for (int i = 1; i <= 4; i++) begin
      in_sample = 16'(i); in_valid = 1'b1;
      tick();
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL prefill_level%0d got %0d exp %0d", i, level, i); end
      checks++; if (running !== (i == 4)) begin errors++; $display("FAIL prefill_running%0d got %b exp %b", i, running, (i == 4)); end
    end
    in_sample = 16'h7FFF; in_valid = 1'b1;
    tick();
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL prefill_level5 got %0d exp 5", level); end
  endtask

  task automatic test_drain_underflow();
    logic [15:0] exp_q [5];
    exp_q[0] = 16'h0001; exp_q[1] = 16'h0002; exp_q[2] = 16'h0003;
    exp_q[3] = 16'h0004; exp_q[4] = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      out_req = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid%0d got %b exp 1", i, out_valid); end
      checks++; if (out_sample !== exp_q[i]) begin errors++; $display("FAIL drain_sample%0d got %h exp %h", i, out_sample, exp_q[i]); end
      checks++; if (level !== 4'(4 - i)) begin errors++; $display("FAIL drain_level%0d got %0d exp %0d", i, level, 4 - i); end
      tick();
      checks++; if (out_sample !== exp_q[i]) begin errors++; $display("FAIL hold_sample%0d got %h exp %h", i, out_sample, exp_q[i]); end
    end
    out_req = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unf_valid got %b exp 1", out_valid); end
    checks++; if (out_sample !== 16'h7FFF) begin errors++; $display("FAIL unf_sample got %h exp 7fff", out_sample); end
    checks++; if (unf_cnt !== 8'(STATS)) begin errors++; $display("FAIL unf_cnt got %0d exp %0d", unf_cnt, STATS); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL unf_running got %b exp 1", running); end
    tick();
  endtask

  task automatic test_write_into_empty();
    in_sample = 16'h0AAA; in_valid = 1'b1; out_req = 1'b1;
    tick();
    checks++; if (out_sample !== 16'h7FFF) begin errors++; $display("FAIL wempty_sample got %h exp 7fff", out_sample); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL wempty_level got %0d exp 1", level); end
    checks++; if (unf_cnt !== 8'(2 * STATS)) begin errors++; $display("FAIL wempty_unf got %0d exp %0d", unf_cnt, 2 * STATS); end
    tick();
    out_req = 1'b1;
    tick();
    checks++; if (out_sample !== 16'h0AAA) begin errors++; $display("FAIL wempty_read got %h exp 0aaa", out_sample); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL wempty_level0 got %0d exp 0", level); end
    tick();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      in_sample = 16'h0100 + 16'(i); in_valid = 1'b1;
      tick();
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_fill_level got %0d exp 8", level); end
    in_sample = 16'h1234; in_valid = 1'b1;
    tick();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
    checks++; if (ovf_cnt !== 8'(STATS)) begin errors++; $display("FAIL ovf_cnt got %0d exp %0d", ovf_cnt, STATS); end
    in_sample = 16'h5555; in_valid = 1'b1; out_req = 1'b1;
    tick();
    checks++; if (out_sample !== 16'h0100) begin errors++; $display("FAIL full_rw_sample got %h exp 0100", out_sample); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_rw_level got %0d exp 8", level); end
    checks++; if (ovf_cnt !== 8'(STATS)) begin errors++; $display("FAIL full_rw_ovf got %0d exp %0d", ovf_cnt, STATS); end
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 7) ? (16'h0101 + 16'(i)) : 16'h5555;
      out_req = 1'b1;
      tick();
      checks++; if (out_sample !== exp_v) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, out_sample, exp_v); end
      tick();
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL ovf_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back_req();
    in_sample = 16'hA001; in_valid = 1'b1;
    tick();
    in_sample = 16'hA002; in_valid = 1'b1;
    tick();
    out_req = 1'b1;
    tick();
    checks++; if (out_sample !== 16'hA001 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp a001/1", out_sample, out_valid); end
    out_req = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ignored got %b exp 0", out_valid); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL b2b_level got %0d exp 1", level); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      in_sample = 16'hB000 + 16'(i); in_valid = 1'b1;
      tick();
    end
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", level); end
    flush = 1'b1; in_valid = 1'b1; in_sample = 16'hCCCC; out_req = 1'b1;
    tick();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL flush_running got %b exp 0", running); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (unf_cnt !== 8'd0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp 0/0", ovf_cnt, unf_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_late got %b exp 0", out_valid); end
    out_req = 1'b1;
    tick();
    checks++; if (out_sample !== 16'h0000 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_fill_out got %h/%b exp 0000/1", out_sample, out_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      in_sample = 16'hD000 + 16'(i); in_valid = 1'b1;
      tick();
    end
    out_req = 1'b1;
    tick();
    checks++; if (running !== 1'b1 || out_sample !== 16'hD000) begin errors++; $display("FAIL rmid_pre got %b/%h exp 1/d000", running, out_sample); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_sample !== 16'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out got %h/%b exp 0000/0", out_sample, out_valid); end
    checks++; if (level !== 4'd0 || running !== 1'b0) begin errors++; $display("FAIL rmid_state got %0d/%b exp 0/0", level, running); end
    checks++; if (ovf_cnt !== 8'd0 || unf_cnt !== 8'd0) begin errors++; $display("FAIL rmid_cnt got %0d/%0d exp 0/0", ovf_cnt, unf_cnt); end
    tick();
    rst_n = 1'b1;
    in_sample = 16'hE001; in_valid = 1'b1;
    tick();
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL rmid_first_write got %0d exp 1", level); end
  endtask

  initial begin
    test_reset();
    test_fill_output();
    test_prefill();
    test_drain_underflow();
    test_write_into_empty();
    test_overflow();
    test_back_to_back_req();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
